// File: rtl/add8u_share_arb.sv
// Round-robin front end for one shared 8-bit adder. Operands are registered,
// the sum is captured one stage later and returned tagged with the requester id.
module add8u_share_arb #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned W     = 8,
  parameter int unsigned IDW   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*W-1:0] req_a,
  input  logic [N_REQ*W-1:0] req_b,
  output logic [N_REQ-1:0]   req_ready,
  output logic [W-1:0]       add_a,
  output logic [W-1:0]       add_b,
  input  logic [W:0]         add_o,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [W:0]         res_sum,
  output logic [IDW-1:0]     res_id,
  output logic               busy,
  output logic [15:0]        ops_done
);

  logic             r_op_valid;
  logic [W-1:0]     r_op_a;
  logic [W-1:0]     r_op_b;
  logic [IDW-1:0]   r_op_id;
  logic             r_res_valid;
  logic [W:0]       r_res_sum;
  logic [IDW-1:0]   r_res_id;
  logic [IDW-1:0]   r_last;
  logic [15:0]      r_ops_done;

  logic             w_adv1;
  logic             w_adv2;
  logic             w_acc;
  logic             w_found;
  logic [IDW-1:0]   w_gidx;
  logic [IDW-1:0]   w_cand;
  logic [N_REQ-1:0] w_grant;

  assign w_adv2 = r_op_valid & (~r_res_valid | res_ready);
  assign w_adv1 = ~r_op_valid | w_adv2;

  // First valid requester after the last winner, wrapping modulo N_REQ.
  always_comb begin
    w_found = 1'b0;
    w_gidx  = '0;
    w_cand  = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      w_cand = IDW'((32'(r_last) + k) % N_REQ);
      if (!w_found && req_valid[w_cand]) begin
        w_found = 1'b1;
        w_gidx  = w_cand;
      end
    end
  end

  // Gated by rst_n so no requester sees a grant while the block is held in reset.
  assign w_acc = w_found & w_adv1 & rst_n;

  always_comb begin
    w_grant = '0;
    if (w_acc) w_grant[w_gidx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_valid  <= 1'b0;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_op_id     <= '0;
      r_res_valid <= 1'b0;
      r_res_sum   <= '0;
      r_res_id    <= '0;
      r_last      <= IDW'(N_REQ - 1);
      r_ops_done  <= '0;
    end else begin
      if (w_acc) begin
        r_op_valid <= 1'b1;
        r_op_a     <= req_a[32'(w_gidx)*W +: W];
        r_op_b     <= req_b[32'(w_gidx)*W +: W];
        r_op_id    <= w_gidx;
        r_last     <= w_gidx;
      end else if (w_adv2) begin
        r_op_valid <= 1'b0;
      end

      if (w_adv2) begin
        r_res_valid <= 1'b1;
        r_res_sum   <= add_o;
        r_res_id    <= r_op_id;
      end else if (r_res_valid && res_ready) begin
        r_res_valid <= 1'b0;
      end

      if (r_res_valid && res_ready && (r_ops_done != '1))
        r_ops_done <= r_ops_done + 16'd1;
    end
  end

  assign req_ready = w_grant;
  assign add_a     = r_op_a;
  assign add_b     = r_op_b;
  assign res_valid = r_res_valid;
  assign res_sum   = r_res_sum;
  assign res_id    = r_res_id;
  assign busy      = r_op_valid | r_res_valid;
  assign ops_done  = r_ops_done;

endmodule
